// File: rtl/serial_abs_16_pkg.sv
// Shared definitions for the bit-serial two's-complement to sign/magnitude decoder.
package serial_abs_16_pkg;

    localparam int ABS_W = 16;
    localparam logic [ABS_W-1:0] OVF_PATTERN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A negative operand whose magnitude decodes back to the MSB-only pattern has no positive form.
    function automatic logic is_ovf(input logic sign, input logic [ABS_W-1:0] res);
        return sign & (res == OVF_PATTERN);
    endfunction

endpackage

// File: rtl/serial_abs_16_neg_bit.sv
// One-bit negation cell: passes bits through until the first 1 is seen, then inverts (for negative operands).
module serial_neg_bit (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic EN,
    input  logic SIGN,
    input  logic B,
    output logic OUT
);

    logic seen_one_r;

    // Remember whether a 1 has already passed through this run.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            seen_one_r <= 1'b0;
        end else if (EN) begin
            seen_one_r <= seen_one_r | B;
        end else begin
            seen_one_r <= seen_one_r;
        end
    end

    assign OUT = B ^ (SIGN & seen_one_r);

endmodule

// File: rtl/serial_abs_16.sv
// Bit-serial |x| decoder: 16 LSB-first shifts through a single negation cell, result in a 1-cycle DONE slot.
module serial_abs_16
    import serial_abs_16_pkg::*;
#(
    parameter int WIDTH = ABS_W,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] MAG,
    output logic             SIGN,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nx_s;
    logic             accept_s;
    logic             shift_en_s;
    logic             last_s;
    logic             out_bit_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] mag_r;
    logic             sign_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    assign shift_en_s = (state_r == ST_SHIFT);
    assign last_s     = shift_en_s && (cnt_r == CNT_LAST);
    assign res_nx_s   = {out_bit_s, res_r[WIDTH-1:1]};

    serial_neg_bit u_neg (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (accept_s),
        .EN   (shift_en_s),
        .SIGN (sign_r),
        .B    (sreg_r[0]),
        .OUT  (out_bit_s)
    );

    // Next-state decode; the DONE slot can take a new START so back-to-back runs cost 17 cycles.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (START) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; MAG/OVF only change when a run completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            sreg_r  <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            mag_r   <= '0;
            sign_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= (state_nx_s == ST_DONE);
            if (accept_s) begin
                sreg_r <= DATA_IN;
                sign_r <= DATA_IN[WIDTH-1];
                res_r  <= '0;
                cnt_r  <= '0;
            end else if (shift_en_s) begin
                sreg_r <= {1'b0, sreg_r[WIDTH-1:1]};
                res_r  <= res_nx_s;
                cnt_r  <= cnt_r + CNT_ONE;
            end
            if (last_s) begin
                mag_r <= res_nx_s;
                ovf_r <= is_ovf(sign_r, res_nx_s);
            end
        end
    end

    assign MAG  = mag_r;
    assign SIGN = sign_r;
    assign OVF  = ovf_r;
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule
